divider_driver: RTL and testbench
=================================

DIVIDER_DRIVER -- requirements
Module: divider_driver

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: operand and result width.
- REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for Done before aborting.
- REQ-003 Clk  input  1  single clock; all logic on rising edge.
- REQ-004 Reset  input  1  synchronous, active-low reset.
- REQ-005 Go  input  1  one-cycle request to start an operation or a sweep; sampled only in IDLE.
- REQ-006 Sweep  input  1  sampled with Go: 0 = single divide of XinU/YinU; 1 = divide XinU by every Y from 1 to 2^WIDTH-1.
- REQ-007 XinU, YinU  input  WIDTH each  user dividend and divisor; sampled with Go.
- REQ-008 Xout, Yout  output  WIDTH each  operands to the divider; held stable from Start until Done.
- REQ-009 Start  output  1  request to the divider.
- REQ-010 Ack  output  1  acknowledge to the divider.
- REQ-011 Done  input  1  divider result valid; held until Ack.
- REQ-012 Quotient, Remainder  input  WIDTH each  divider results; valid while Done=1.
- REQ-013 Busy  output  1  high in every state except IDLE.
- REQ-014 BatchDone  output  1  one-cycle pulse when a single op or sweep completes or aborts.
- REQ-015 PassCount  output  WIDTH+1  number of checked results that were correct.
- REQ-016 ErrCount  output  WIDTH+1  number of checked results that were wrong.
- REQ-017 LastQ, LastR  output  WIDTH each  most recently captured Quotient/Remainder.
- REQ-018 ErrY  output  WIDTH  divisor of the first failing op; holds until the next Go.
- REQ-019 TimeoutErr, DivZeroErr  output  1 each  sticky status flags, cleared by the next accepted Go.

Function
- REQ-020 States SHALL be IDLE, LOAD, START, WAIT_DONE, CHECK, ACK, WAIT_REL, NEXT.
- REQ-021 IDLE->LOAD on Go=1, which also clears the counters, ErrY, and the flags.
- REQ-022 In single mode with YinU=0, the driver SHALL set DivZeroErr, pulse BatchDone, return to IDLE, and never assert Start.
- REQ-023 LOAD SHALL drive Xout=XinU and Yout=YinU (single) or Yout=1 (sweep), then go to START.
- REQ-024 START SHALL assert Start for exactly one cycle, then go to WAIT_DONE.
- REQ-025 WAIT_DONE SHALL count cycles; on Done=1 it goes to CHECK; when the count reaches TIMEOUT it sets TimeoutErr, pulses BatchDone, and returns to IDLE.
- REQ-026 CHECK SHALL capture LastQ and LastR.
- REQ-027 CHECK SHALL compute Q*Yout+R at 2*WIDTH bits.
- REQ-028 In CHECK, a result is a pass when Q*Yout+R == Xout and R < Yout; pass increments PassCount, otherwise ErrCount increments and ErrY is captured if ErrCount was 0.
- REQ-029 ACK SHALL assert Ack for exactly one cycle, then go to WAIT_REL.
- REQ-030 WAIT_REL SHALL wait for Done=0, using the same TIMEOUT rule as WAIT_DONE.
- REQ-031 WAIT_REL SHALL then go to NEXT.
- REQ-032 In NEXT, single mode or Yout = 2^WIDTH-1 SHALL pulse BatchDone and go to IDLE; otherwise Yout increments with no wrap to 0 and the state goes to START.
- REQ-033 Start and Ack SHALL never be high in the same cycle; Start SHALL never be asserted while Done=1.
- REQ-034 Go while Busy SHALL be ignored.
- REQ-035 Counters SHALL saturate at all-ones.

Reset
- REQ-036 With Reset=0 at a rising edge, state=IDLE and every output, counter, flag and captured register SHALL be 0 by the next cycle, including mid-handshake.
- REQ-037 After reset in a handshake state, the driver SHALL wait for Done=0 before accepting a new Go.

Structure
- REQ-038 Shared package divider_drv_pkg SHALL hold the state enum, the default WIDTH, and the default TIMEOUT.
- REQ-039 The combinational pass/fail check SHALL be the sub-module divider_result_checker (inputs X, Y, Q, R; output pass).
- REQ-040 The rest of the FSM, counters and timeout SHALL reside in divider_driver.

Verification
- REQ-041 Single op, XinU=100, YinU=7, with a behavioural divider model: Q=14, R=2, PassCount=1, ErrCount=0, one BatchDone pulse, one Start pulse and one Ack pulse.
- REQ-042 Sweep with XinU=255 and a correct model: 255 ops, PassCount=255, ErrCount=0, final Yout=255, BatchDone once.
- REQ-043 Model returning R=Y at Y=5 (X=40): ErrCount=1, ErrY=5, sweep still completes with PassCount=254.
- REQ-044 Model that never raises Done: TimeoutErr=1 after 1023 cycles in WAIT_DONE, BatchDone pulse, state IDLE, Start not reasserted.
- REQ-045 YinU=0 single op: DivZeroErr=1, no Start ever, Busy returns low within 2 cycles.
- REQ-046 Reset low during WAIT_DONE of a sweep: all outputs 0 next cycle; a second Go while Busy has no effect on counters.

Source files
------------

// File: rtl/divider_drv_pkg.sv
// Shared definitions for the divider driver: FSM state encoding and default sizing.
package divider_drv_pkg;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        CHECK,
        ACK,
        WAIT_REL,
        NEXT
    } state_t;
endpackage

// File: rtl/divider_result_checker.sv
// Combinational check of one divide result: Q*Y+R must rebuild X and R must be below Y.
// Zero latency, no flow control; the caller decides when the inputs are meaningful.
module divider_result_checker
    import divider_drv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_r,
    output logic             o_pass
);
    logic [2*WIDTH-1:0] w_recon;

    // Full double-width product so Q*Y cannot wrap back onto X
    assign w_recon = ({{WIDTH{1'b0}}, i_q} * {{WIDTH{1'b0}}, i_y}) + {{WIDTH{1'b0}}, i_r};
    assign o_pass  = (w_recon == {{WIDTH{1'b0}}, i_x}) && (i_r < i_y);
endmodule

// File: rtl/divider_driver.sv
// Drives a Start/Done/Ack divider for single ops or full-divisor sweeps and scores each result.
// One op takes START + divider latency + CHECK/ACK/WAIT_REL/NEXT; Go is ignored while busy or while Done is still high.
module divider_driver
    import divider_drv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_go,
    input  logic             i_sweep,
    input  logic [WIDTH-1:0] i_xin_u,
    input  logic [WIDTH-1:0] i_yin_u,
    output logic [WIDTH-1:0] o_xout,
    output logic [WIDTH-1:0] o_yout,
    output logic             o_start,
    output logic             o_ack,
    input  logic             i_done,
    input  logic [WIDTH-1:0] i_quotient,
    input  logic [WIDTH-1:0] i_remainder,
    output logic             o_busy,
    output logic             o_batch_done,
    output logic [WIDTH:0]   o_pass_count,
    output logic [WIDTH:0]   o_err_count,
    output logic [WIDTH-1:0] o_last_q,
    output logic [WIDTH-1:0] o_last_r,
    output logic [WIDTH-1:0] o_err_y,
    output logic             o_timeout_err,
    output logic             o_div_zero_err
);
    localparam int                TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0]  Y_MAX    = '1;
    localparam logic [WIDTH:0]    CNT_MAX  = '1;

    state_t           r_state;
    logic             r_sweep;
    logic [WIDTH-1:0] r_xout, r_yout, r_last_q, r_last_r, r_err_y;
    logic [WIDTH:0]   r_pass_cnt, r_err_cnt;
    logic             r_start, r_ack, r_batch_done, r_tmo_err, r_dz_err;
    logic [TW-1:0]    r_tmo;
    logic             w_pass;

    divider_result_checker #(.WIDTH(WIDTH)) u_checker (
        .i_x    (r_xout),
        .i_y    (r_yout),
        .i_q    (i_quotient),
        .i_r    (i_remainder),
        .o_pass (w_pass)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_sweep      <= 1'b0;
            r_xout       <= '0;
            r_yout       <= '0;
            r_last_q     <= '0;
            r_last_r     <= '0;
            r_err_y      <= '0;
            r_pass_cnt   <= '0;
            r_err_cnt    <= '0;
            r_start      <= 1'b0;
            r_ack        <= 1'b0;
            r_batch_done <= 1'b0;
            r_tmo_err    <= 1'b0;
            r_dz_err     <= 1'b0;
            r_tmo        <= '0;
        end else begin
            r_start      <= 1'b0;
            r_ack        <= 1'b0;
            r_batch_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A Done left over from an interrupted handshake must drain first
                    if (i_go && !i_done) begin
                        r_pass_cnt <= '0;
                        r_err_cnt  <= '0;
                        r_err_y    <= '0;
                        r_tmo_err  <= 1'b0;
                        r_sweep    <= i_sweep;
                        if (!i_sweep && i_yin_u == '0) begin
                            r_dz_err     <= 1'b1;
                            r_batch_done <= 1'b1;
                        end else begin
                            r_dz_err <= 1'b0;
                            r_xout   <= i_xin_u;
                            r_yout   <= i_sweep ? WIDTH'(1) : i_yin_u;
                            r_state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    r_start <= 1'b1;
                    r_state <= START;
                end
                START: begin
                    r_tmo   <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_done) begin
                        r_state <= CHECK;
                    end else if (r_tmo == TMO_LAST) begin
                        r_tmo_err    <= 1'b1;
                        r_batch_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                CHECK: begin
                    r_last_q <= i_quotient;
                    r_last_r <= i_remainder;
                    if (w_pass) begin
                        if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + 1'b1;
                    end else begin
                        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
                        if (r_err_cnt == '0) r_err_y <= r_yout;
                    end
                    r_ack   <= 1'b1;
                    r_state <= ACK;
                end
                ACK: begin
                    r_tmo   <= '0;
                    r_state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!i_done) begin
                        r_state <= NEXT;
                    end else if (r_tmo == TMO_LAST) begin
                        r_tmo_err    <= 1'b1;
                        r_batch_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                NEXT: begin
                    if (!r_sweep || r_yout == Y_MAX) begin
                        r_batch_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_yout  <= r_yout + 1'b1;
                        r_start <= 1'b1;
                        r_state <= START;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_xout         = r_xout;
    assign o_yout         = r_yout;
    assign o_start        = r_start;
    assign o_ack          = r_ack;
    assign o_busy         = (r_state != IDLE);
    assign o_batch_done   = r_batch_done;
    assign o_pass_count   = r_pass_cnt;
    assign o_err_count    = r_err_cnt;
    assign o_last_q       = r_last_q;
    assign o_last_r       = r_last_r;
    assign o_err_y        = r_err_y;
    assign o_timeout_err  = r_tmo_err;
    assign o_div_zero_err = r_dz_err;
endmodule

// File: tb/tb_divider_driver.sv
// Bench for divider_driver: behavioural divider model plus a batch-level scoreboard.
module tb_divider_driver;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 1023;

    logic             clk = 1'b0;
    logic             rst_n, go, sweep, done;
    logic [WIDTH-1:0] xin, yin, quot, rem;
    logic [WIDTH-1:0] o_xout, o_yout, o_last_q, o_last_r, o_err_y;
    logic             o_start, o_ack, o_busy, o_batch_done, o_timeout_err, o_div_zero_err;
    logic [WIDTH:0]   o_pass_count, o_err_count;

    typedef struct {
        int pass_c; int err_c; int err_y; int last_q; int last_r;
        int tmo; int dz; int yout; int starts; int acks;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mode     = 0;
    int   start_cnt = 0, ack_cnt = 0, viol = 0;

    always #5 clk = ~clk;

    divider_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_go(go), .i_sweep(sweep),
        .i_xin_u(xin), .i_yin_u(yin), .o_xout(o_xout), .o_yout(o_yout),
        .o_start(o_start), .o_ack(o_ack), .i_done(done),
        .i_quotient(quot), .i_remainder(rem), .o_busy(o_busy),
        .o_batch_done(o_batch_done), .o_pass_count(o_pass_count),
        .o_err_count(o_err_count), .o_last_q(o_last_q), .o_last_r(o_last_r),
        .o_err_y(o_err_y), .o_timeout_err(o_timeout_err), .o_div_zero_err(o_div_zero_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Divider model: 3-cycle latency, holds Done until Ack; mode 1 corrupts R at Y=5, mode 2 never answers
    initial begin
        int dly, mx, my;
        bit prev_bd;
        dly = 0; mx = 0; my = 1; prev_bd = 0;
        done = 1'b0; quot = '0; rem = '0;
        forever begin
            @(posedge clk); #1;
            if (prev_bd) begin start_cnt = 0; ack_cnt = 0; end
            prev_bd = o_batch_done;
            if (!rst_n) begin
                done = 1'b0; dly = 0; start_cnt = 0; ack_cnt = 0;
            end else begin
                if (o_start && done)  viol++;
                if (o_start && o_ack) viol++;
                if (o_start) begin
                    start_cnt++; dly = 3; mx = o_xout; my = o_yout;
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0 && mode != 2) begin
                        done = 1'b1;
                        quot = WIDTH'(mx / my);
                        rem  = (mode == 1 && my == 5) ? WIDTH'(my) : WIDTH'(mx % my);
                    end
                end
                if (o_ack) begin ack_cnt++; done = 1'b0; end
            end
        end
    end

    // Scoreboard monitor: every BatchDone pulse consumes one expected batch result
    always @(negedge clk) begin
        if (rst_n && o_batch_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_batch_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pass_count", int'(o_pass_count), e.pass_c);
                chk("err_count",  int'(o_err_count),  e.err_c);
                chk("err_y",      int'(o_err_y),      e.err_y);
                chk("last_q",     int'(o_last_q),     e.last_q);
                chk("last_r",     int'(o_last_r),     e.last_r);
                chk("timeout_err", int'(o_timeout_err), e.tmo);
                chk("div_zero_err", int'(o_div_zero_err), e.dz);
                if (e.yout >= 0) chk("yout", int'(o_yout), e.yout);
                chk("start_pulses", start_cnt, e.starts);
                chk("ack_pulses",   ack_cnt,   e.acks);
            end
        end
    end

    task automatic push(input int pc, input int ec, input int ey, input int q, input int r,
                        input int tmo, input int dz, input int yo, input int st, input int ak);
        exp_t e;
        e.pass_c = pc; e.err_c = ec; e.err_y = ey; e.last_q = q; e.last_r = r;
        e.tmo = tmo; e.dz = dz; e.yout = yo; e.starts = st; e.acks = ak;
        sb.push_back(e);
    endtask

    task automatic do_go(input logic sw, input int x, input int y);
        @(posedge clk); #1;
        go = 1'b1; sweep = sw; xin = WIDTH'(x); yin = WIDTH'(y);
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_sb(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_batch_timeout"}, sb.size(), 0);
    endtask

    task automatic chk_zero(input string name);
        chk(name, int'(|{o_xout, o_yout, o_start, o_ack, o_busy, o_batch_done, o_pass_count,
                         o_err_count, o_last_q, o_last_r, o_err_y, o_timeout_err, o_div_zero_err}), 0);
    endtask

    initial begin
        int lat, n;
        rst_n = 1'b0; go = 1'b0; sweep = 1'b0; xin = '0; yin = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_outputs");
        rst_n = 1'b1;

        // Single op 100/7
        push(1, 0, 0, 14, 2, 0, 0, 7, 1, 1);
        do_go(1'b0, 100, 7);
        wait_sb("single", 200);

        // Full sweep of 255 with a Go issued mid-sweep that must be ignored
        push(255, 0, 0, 1, 0, 0, 0, 255, 255, 255);
        do_go(1'b1, 255, 0);
        repeat (100) @(posedge clk);
        do_go(1'b0, 3, 1);
        wait_sb("sweep", 5000);

        // Sweep of 40 where the model returns R=Y at Y=5
        mode = 1;
        push(254, 1, 5, 0, 40, 0, 0, 255, 255, 255);
        do_go(1'b1, 40, 0);
        wait_sb("sweep_bad", 5000);
        mode = 0;

        // Divider never answers: abort after TIMEOUT cycles in WAIT_DONE
        mode = 2;
        push(0, 0, 0, 0, 40, 1, 0, 3, 1, 0);
        do_go(1'b0, 9, 3);
        n = 0;
        while (!o_start && n < 10) begin @(posedge clk); #1; n++; end
        lat = 0;
        while (!o_batch_done && lat < TIMEOUT + 50) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat < TIMEOUT || lat > TIMEOUT + 2) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", lat, TIMEOUT, TIMEOUT + 2);
        end
        wait_sb("timeout", 50);
        repeat (20) @(posedge clk);
        #1;
        chk("timeout_no_restart", start_cnt, 0);
        chk("timeout_idle", int'(o_busy), 0);
        mode = 0;

        // Divide by zero in single mode
        push(0, 0, 0, 0, 40, 0, 1, -1, 0, 0);
        do_go(1'b0, 50, 0);
        @(posedge clk); #1;
        chk("divzero_busy_low", int'(o_busy), 0);
        wait_sb("divzero", 20);

        // Reset while a sweep is waiting on the divider
        do_go(1'b1, 200, 0);
        n = 0;
        while (start_cnt < 3 && n < 200) begin @(posedge clk); #1; n++; end
        chk("sweep_reached_3rd_op", int'(start_cnt >= 3), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("midsweep_reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Recovery after reset
        push(1, 0, 0, 14, 2, 0, 0, 7, 1, 1);
        do_go(1'b0, 100, 7);
        wait_sb("post_reset_single", 200);

        repeat (5) @(posedge clk);
        #1;
        chk("protocol_violations", viol, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
